// File: rtl/alu_pkg.sv
// Shared constants and types for the execute-stage ALU.
package alu_pkg;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned SHAMT_W = 5;

  localparam logic [3:0] OP_AND    = 4'b0000;
  localparam logic [3:0] OP_OR     = 4'b0001;
  localparam logic [3:0] OP_ADD    = 4'b0010;
  localparam logic [3:0] OP_SUB    = 4'b0011;
  localparam logic [3:0] OP_SLT    = 4'b0100;
  localparam logic [3:0] OP_SLTU   = 4'b0101;
  localparam logic [3:0] OP_XOR    = 4'b0110;
  localparam logic [3:0] OP_NOR    = 4'b0111;
  localparam logic [3:0] OP_SLL    = 4'b1000;
  localparam logic [3:0] OP_SRL    = 4'b1001;
  localparam logic [3:0] OP_SRA    = 4'b1010;
  localparam logic [3:0] OP_ROL    = 4'b1011;
  localparam logic [3:0] OP_ROR    = 4'b1100;
  localparam logic [3:0] OP_PASSB  = 4'b1101;
  localparam logic [3:0] OP_RSVD_E = 4'b1110;
  localparam logic [3:0] OP_RSVD_F = 4'b1111;

  // Shifter operating mode.
  typedef enum logic [2:0] {
    SH_SLL = 3'd0,
    SH_SRL = 3'd1,
    SH_SRA = 3'd2,
    SH_ROL = 3'd3,
    SH_ROR = 3'd4
  } sh_mode_e;

endpackage

// File: rtl/alu_shifter.sv
// Combinational 5-stage barrel shifter/rotator.
module alu_shifter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0]   data,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [2:0]         mode,
  output logic [WIDTH-1:0]   result
);

  sh_mode_e         m;
  logic             left;
  logic             rot;
  logic             fill;
  logic [WIDTH-1:0] src;
  logic [WIDTH-1:0] stage;
  logic [WIDTH-1:0] ones;

  // Left operations are done as right operations on the bit-reversed word,
  // so a single right-shifting stage chain serves all five modes.
  always_comb begin
    m     = sh_mode_e'(mode);
    left  = (m == SH_SLL) || (m == SH_ROL);
    rot   = (m == SH_ROL) || (m == SH_ROR);
    fill  = (m == SH_SRA) && data[WIDTH-1];
    ones  = '1;
    src   = '0;
    stage = '0;
    result = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      src[i] = left ? data[WIDTH-1-i] : data[i];
    end
    stage = src;
    for (int unsigned i = 0; i < SHAMT_W; i++) begin
      if (shamt[i]) begin
        if (rot) begin
          stage = (stage >> (1 << i)) | (stage << (WIDTH - (1 << i)));
        end else begin
          stage = (stage >> (1 << i)) | (fill ? ~(ones >> (1 << i)) : '0);
        end
      end
    end
    for (int unsigned i = 0; i < WIDTH; i++) begin
      result[i] = left ? stage[WIDTH-1-i] : stage[i];
    end
  end

endmodule

// File: rtl/alu.sv
// 32-bit registered integer ALU with Zero and signed-overflow flags.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = alu_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       Op,
  output logic [WIDTH-1:0] Out,
  output logic             Zero,
  output logic             Ovf
);

  logic             sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] addsub;
  logic [WIDTH-1:0] sh_res;
  logic [2:0]       sh_mode;
  logic [WIDTH-1:0] r;
  logic             ovf;

  // Shared adder: subtraction is A + ~B + 1.
  always_comb begin
    sub    = (Op == OP_SUB);
    b_eff  = sub ? ~B : B;
    addsub = A + b_eff + WIDTH'(sub);
  end

  // Map shift/rotate op codes onto shifter modes.
  always_comb begin
    sh_mode = SH_SLL;
    case (Op)
      OP_SRL:  sh_mode = SH_SRL;
      OP_SRA:  sh_mode = SH_SRA;
      OP_ROL:  sh_mode = SH_ROL;
      OP_ROR:  sh_mode = SH_ROR;
      default: sh_mode = SH_SLL;
    endcase
  end

  alu_shifter #(.WIDTH(WIDTH)) u_shifter (
    .data   (A),
    .shamt  (B[SHAMT_W-1:0]),
    .mode   (sh_mode),
    .result (sh_res)
  );

  // Result mux and overflow; unknown or reserved op codes yield zero.
  always_comb begin
    r   = '0;
    ovf = 1'b0;
    case (Op)
      OP_AND:   r = A & B;
      OP_OR:    r = A | B;
      OP_ADD: begin
        r   = addsub;
        ovf = (A[WIDTH-1] == B[WIDTH-1]) && (addsub[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        r   = addsub;
        ovf = (A[WIDTH-1] != B[WIDTH-1]) && (addsub[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SLT:   r = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU:  r = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_XOR:   r = A ^ B;
      OP_NOR:   r = ~(A | B);
      OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR: r = sh_res;
      OP_PASSB: r = B;
      default: begin
        r   = '0;
        ovf = 1'b0;
      end
    endcase
  end

  // Output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      Out  <= '0;
      Zero <= 1'b1;
      Ovf  <= 1'b0;
    end else begin
      Out  <= r;
      Zero <= (r == '0);
      Ovf  <= ovf;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Scoreboard testbench for alu.
module tb_alu;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  Op;
  logic [31:0] Out;
  logic        Zero;
  logic        Ovf;

  typedef struct {
    string       tag;
    logic [31:0] out;
    logic        zero;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  alu #(.WIDTH(32)) dut (
    .clk  (clk),
    .rst  (rst),
    .A    (A),
    .B    (B),
    .Op   (Op),
    .Out  (Out),
    .Zero (Zero),
    .Ovf  (Ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Independent reference model.
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint s;
    int     n;
    n = int'(b[4:0]);
    e.tag = "rand";
    e.ovf = 1'b0;
    e.out = 32'h0;
    case (op)
      4'd0:  e.out = a & b;
      4'd1:  e.out = a | b;
      4'd2: begin
        s = longint'($signed(a)) + longint'($signed(b));
        e.out = a + b;
        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd3: begin
        s = longint'($signed(a)) - longint'($signed(b));
        e.out = a - b;
        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd4:  e.out = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd5:  e.out = (a < b) ? 32'd1 : 32'd0;
      4'd6:  e.out = a ^ b;
      4'd7:  e.out = ~(a | b);
      4'd8:  e.out = a << n;
      4'd9:  e.out = a >> n;
      4'd10: e.out = $signed(a) >>> n;
      4'd11: e.out = (n == 0) ? a : ((a << n) | (a >> (32 - n)));
      4'd12: e.out = (n == 0) ? a : ((a >> n) | (a << (32 - n)));
      4'd13: e.out = b;
      default: e.out = 32'h0;
    endcase
    e.zero = (e.out == 32'h0);
    return e;
  endfunction

  // Drive one cycle, push the expectation, then compare after the edge.
  task automatic cycle(input string tag, input logic r, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eo, input logic ev, input logic use_model);
    exp_t e;
    exp_t got;
    rst = r; Op = op; A = a; B = b;
    if (r) begin
      e.out = 32'h0; e.zero = 1'b1; e.ovf = 1'b0;
    end else if (use_model) begin
      e = model(op, a, b);
    end else begin
      e.out = eo; e.zero = (eo == 32'h0); e.ovf = ev;
    end
    e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      got = sb.pop_front();
      chk({got.tag, ".out"},  Out,          got.out);
      chk({got.tag, ".zero"}, {31'h0, Zero}, {31'h0, got.zero});
      chk({got.tag, ".ovf"},  {31'h0, Ovf},  {31'h0, got.ovf});
    end
  endtask

  initial begin
    rst = 1'b1; A = '0; B = '0; Op = OP_AND;
    @(negedge clk);

    // Reset behaviour
    cycle("rst0", 1, OP_ADD, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0);
    cycle("rst1", 1, OP_ADD, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0);
    cycle("rst_rel", 0, OP_ADD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, 0);

    // Op sweep with A=B=12
    cycle("and12",  0, OP_AND,    32'd12, 32'd12, 32'd12,       0, 0);
    cycle("or12",   0, OP_OR,     32'd12, 32'd12, 32'd12,       0, 0);
    cycle("add12",  0, OP_ADD,    32'd12, 32'd12, 32'd24,       0, 0);
    cycle("sub12",  0, OP_SUB,    32'd12, 32'd12, 32'd0,        0, 0);
    cycle("slt12",  0, OP_SLT,    32'd12, 32'd12, 32'd0,        0, 0);
    cycle("sll12",  0, OP_SLL,    32'd12, 32'd12, 32'h0000C000, 0, 0);
    cycle("rsvdE",  0, OP_RSVD_E, 32'd12, 32'd12, 32'd0,        0, 0);
    cycle("rsvdF",  0, OP_RSVD_F, 32'hFFFFFFFF, 32'h1, 32'd0,   0, 0);

    // Overflow
    cycle("add_ovf",  0, OP_ADD, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1, 0);
    cycle("sub_ovf",  0, OP_SUB, 32'h80000000, 32'h1, 32'h7FFFFFFF, 1, 0);
    cycle("add_wrap", 0, OP_ADD, 32'hFFFFFFFF, 32'h1, 32'h0,        0, 0);
    cycle("sub_novf", 0, OP_SUB, 32'h00000005, 32'h7, 32'hFFFFFFFE, 0, 0);

    // Compare
    cycle("slt_neg",  0, OP_SLT,  32'hFFFFFFFF, 32'h1,        32'h1, 0, 0);
    cycle("sltu_big", 0, OP_SLTU, 32'hFFFFFFFF, 32'h1,        32'h0, 0, 0);
    cycle("slt_ovf",  0, OP_SLT,  32'h80000000, 32'h7FFFFFFF, 32'h1, 0, 0);
    cycle("sltu_sm",  0, OP_SLTU, 32'h1,        32'hFFFFFFFF, 32'h1, 0, 0);

    // Shifts
    cycle("srl4",  0, OP_SRL, 32'h80000001, 32'd4,  32'h08000000, 0, 0);
    cycle("sra4",  0, OP_SRA, 32'h80000001, 32'd4,  32'hF8000000, 0, 0);
    cycle("rol4",  0, OP_ROL, 32'h80000001, 32'd4,  32'h00000018, 0, 0);
    cycle("ror4",  0, OP_ROR, 32'h80000001, 32'd4,  32'h18000000, 0, 0);
    cycle("sll32", 0, OP_SLL, 32'h80000001, 32'd32, 32'h80000001, 0, 0);
    cycle("sll31", 0, OP_SLL, 32'h80000001, 32'd31, 32'h80000000, 0, 0);
    cycle("ror31", 0, OP_ROR, 32'h80000001, 32'd31, 32'h00000003, 0, 0);

    // Logic / misc
    cycle("xor",   0, OP_XOR,   32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 0, 0);
    cycle("nor",   0, OP_NOR,   32'hF0F0F0F0, 32'h0FF00FF0, 32'h000F000F, 0, 0);
    cycle("passb", 0, OP_PASSB, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h0FF00FF0, 0, 0);

    // Reset arriving with a PASSB in flight: PASSB result must never appear
    cycle("xor_pre", 0, OP_XOR,   32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 0, 0);
    cycle("rst_mid", 1, OP_PASSB, 32'hF0F0F0F0, 32'h0FF00FF0, 0, 0, 0);
    cycle("post_rst", 0, OP_OR,   32'h00000001, 32'h00000002, 32'h00000003, 0, 0);

    // Randomised vectors against the reference model
    for (int i = 0; i < 200; i++) begin
      cycle("rand", 0, 4'($urandom_range(0, 15)), $urandom, $urandom, 0, 0, 1);
    end
    for (int i = 0; i < 60; i++) begin
      cycle("rand_sh", 0, 4'($urandom_range(8, 12)), $urandom, 32'($urandom_range(0, 63)), 0, 0, 1);
    end

    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
